// File: rtl/ht_client.sv
// ht_client: host-side initiator for the hash-table command/result interface, with credit flow control,
// in-order result checking and a lost-result watchdog. Define HT_CLIENT_STATS_EN for ok/fail result counters.
module ht_client #(
  parameter int KEY_WIDTH       = 32,
  parameter int VALUE_WIDTH     = 16,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [1:0]             host_req_cmd_i,
  input  logic [KEY_WIDTH-1:0]   host_req_key_i,
  input  logic [VALUE_WIDTH-1:0] host_req_value_i,
  input  logic                   host_req_valid_i,
  output logic                   host_req_ready_o,
  output logic [1:0]             ht_cmd_cmd_o,
  output logic [KEY_WIDTH-1:0]   ht_cmd_key_o,
  output logic [VALUE_WIDTH-1:0] ht_cmd_value_o,
  output logic                   ht_cmd_valid_o,
  input  logic                   ht_cmd_ready_i,
  input  logic [2:0]             ht_res_rescode_i,
  input  logic [KEY_WIDTH-1:0]   ht_res_key_i,
  input  logic [VALUE_WIDTH-1:0] ht_res_value_i,
  input  logic                   ht_res_valid_i,
  output logic [2:0]             host_res_rescode_o,
  output logic [KEY_WIDTH-1:0]   host_res_key_o,
  output logic [VALUE_WIDTH-1:0] host_res_value_o,
  output logic                   host_res_valid_o,
  input  logic                   host_res_ready_i,
  input  logic                   err_clear_i,
  output logic [2:0]             err_o,
  output logic                   busy_o
`ifdef HT_CLIENT_STATS_EN
  ,
  output logic [31:0]            stat_ok_cnt_o,
  output logic [31:0]            stat_fail_cnt_o
`endif
);

  localparam int AW = $clog2(MAX_OUTSTANDING);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = 3 + KEY_WIDTH + VALUE_WIDTH;

  typedef enum logic {RUN, HALT} state_t;

  state_t               state;
  logic                 init_done;
  logic [CW-1:0]        credits;
  logic                 vld_p1;
  logic [1:0]           cmd_p1;
  logic [KEY_WIDTH-1:0] key_p1;
  logic [VALUE_WIDTH-1:0] value_p1;
  logic [PW-1:0]        exp_wr, exp_rd, res_wr, res_rd;
  logic [KEY_WIDTH-1:0] exp_mem [MAX_OUTSTANDING];
  logic [RW-1:0]        res_mem [MAX_OUTSTANDING];
  logic [WW-1:0]        wd_cnt;
  logic [2:0]           err_q;
  logic [2:0]           err_new;
  logic [KEY_WIDTH-1:0] exp_key;
  logic req_hs, cmd_hs, res_hs, res_push, exp_empty, res_empty, res_full, halt_clear;

  // init_done keeps ready low while reset is asserted even though the FSM already sits in RUN
  assign host_req_ready_o = init_done && (state == RUN) && (credits != '0) && (!vld_p1 || ht_cmd_ready_i);
  assign req_hs    = host_req_valid_i && host_req_ready_o;
  assign cmd_hs    = vld_p1 && ht_cmd_ready_i;
  assign exp_empty = (exp_wr == exp_rd);
  assign res_empty = (res_wr == res_rd);
  assign res_full  = (res_wr[AW] != res_rd[AW]) && (res_wr[AW-1:0] == res_rd[AW-1:0]);
  assign res_hs    = !res_empty && host_res_ready_i;
  assign res_push  = ht_res_valid_i && !exp_empty && !res_full;
  assign exp_key   = exp_mem[exp_rd[AW-1:0]];

  assign err_new[0] = ht_res_valid_i && !exp_empty && (ht_res_key_i != exp_key);
  assign err_new[1] = ht_res_valid_i && exp_empty;
  assign err_new[2] = !exp_empty && !ht_res_valid_i && (wd_cnt == WW'(TIMEOUT_CYCLES - 1));
  assign halt_clear = (state == HALT) && err_clear_i && (err_new == 3'b000);

  assign ht_cmd_valid_o = vld_p1;
  assign ht_cmd_cmd_o   = cmd_p1;
  assign ht_cmd_key_o   = key_p1;
  assign ht_cmd_value_o = value_p1;

  assign host_res_valid_o = !res_empty;
  assign {host_res_rescode_o, host_res_key_o, host_res_value_o} = res_mem[res_rd[AW-1:0]];

  assign err_o  = err_q;
  assign busy_o = (credits != CW'(MAX_OUTSTANDING));

  // Stage p1: command register and FIFO storage (data only)
  always_ff @(posedge clk_i) begin
    if (req_hs) begin
      cmd_p1   <= host_req_cmd_i;
      key_p1   <= host_req_key_i;
      value_p1 <= host_req_value_i;
    end
    if (cmd_hs)
      exp_mem[exp_wr[AW-1:0]] <= key_p1;
    if (res_push)
      res_mem[res_wr[AW-1:0]] <= {ht_res_rescode_i, ht_res_key_i, ht_res_value_i};
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      init_done <= 1'b0;
      state     <= RUN;
      credits   <= CW'(MAX_OUTSTANDING);
      vld_p1    <= 1'b0;
      exp_wr    <= '0;
      exp_rd    <= '0;
      res_wr    <= '0;
      res_rd    <= '0;
      wd_cnt    <= '0;
      err_q     <= 3'b000;
    end else begin
      init_done <= 1'b1;
      if (req_hs && !res_hs)
        credits <= credits - 1'b1;
      else if (!req_hs && res_hs)
        credits <= credits + 1'b1;

      if (req_hs)
        vld_p1 <= 1'b1;
      else if (ht_cmd_ready_i)
        vld_p1 <= 1'b0;

      if (cmd_hs)
        exp_wr <= exp_wr + 1'b1;
      if (ht_res_valid_i && !exp_empty)
        exp_rd <= exp_rd + 1'b1;
      if (res_push)
        res_wr <= res_wr + 1'b1;
      if (res_hs)
        res_rd <= res_rd + 1'b1;

      // watchdog saturates at the limit so the timeout flag fires exactly once
      if (exp_empty || ht_res_valid_i || halt_clear)
        wd_cnt <= '0;
      else if (wd_cnt != WW'(TIMEOUT_CYCLES))
        wd_cnt <= wd_cnt + 1'b1;

      if (err_new != 3'b000) begin
        err_q <= err_q | err_new;
        state <= HALT;
      end else if (err_clear_i) begin
        err_q <= 3'b000;
        state <= RUN;
      end
    end
  end

`ifdef HT_CLIENT_STATS_EN
  localparam logic [2:0] RES_SEARCH_FOUND            = 3'd0;
  localparam logic [2:0] RES_INSERT_SUCCESS          = 3'd2;
  localparam logic [2:0] RES_INSERT_SUCCESS_SAME_KEY = 3'd3;
  localparam logic [2:0] RES_DELETE_SUCCESS          = 3'd5;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic res_ok;
  assign res_ok = (host_res_rescode_o == RES_SEARCH_FOUND) ||
                  (host_res_rescode_o == RES_INSERT_SUCCESS) ||
                  (host_res_rescode_o == RES_INSERT_SUCCESS_SAME_KEY) ||
                  (host_res_rescode_o == RES_DELETE_SUCCESS);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stat_ok_cnt_o   <= 32'd0;
      stat_fail_cnt_o <= 32'd0;
    end else if (res_hs) begin
      if (res_ok)
        stat_ok_cnt_o <= sat_inc(stat_ok_cnt_o);
      else
        stat_fail_cnt_o <= sat_inc(stat_fail_cnt_o);
    end
  end
`endif

endmodule
